// File: rtl/stream_deserializer.sv
// -----------------------------------------------------------------------------
// stream_deserializer
//   Rebuilds N-word frames from one serial AXI-Stream. Each frame goes out on
//   N parallel AXI-Stream lanes at the same time. While a frame is on the
//   lanes, the input is held off. Each lane's valid clears on that lane's own
//   handshake.
//
//   Optional framing checker: define STREAM_DESERIALIZER_CHECK_EN to compile it
//   in. The checker compares tid and tlast against the word's frame position.
//   On a bad word it pulses err and drops the partial frame. Without the macro,
//   tid and tlast are ignored and err is tied to 0.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        serial input stream (tdata, tvalid, tready, tid, tlast)
//   m_axis_tdata    per-lane output data   [N]
//   m_axis_tvalid   per-lane output valid  [N]
//   m_axis_tready   per-lane output ready  [N]
//   err             one-cycle framing-error pulse
//
// state    | meaning
// ---------+------------------------------------------------------------
// FILL     | accepting words into the frame buffer
// PRESENT  | frame on the output lanes, waiting for every lane to accept
// DROP     | (checker only) discarding words up to the next tlast
// -----------------------------------------------------------------------------
module stream_deserializer #(
  parameter int DW   = 24,
  parameter int N    = 4,
  parameter int TIDW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [TIDW-1:0] s_axis_tid,
  input  logic            s_axis_tlast,
  output logic [DW-1:0]   m_axis_tdata  [N],
  output logic            m_axis_tvalid [N],
  input  logic            m_axis_tready [N],
  output logic            err
);

  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PRESENT
`ifdef STREAM_DESERIALIZER_CHECK_EN
    , ST_DROP
`endif
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_idx;
  logic [DW-1:0]   r_buf   [N-1];
  logic [DW-1:0]   r_mdata [N];
  logic [N-1:0]    r_mvalid;

  state_t          w_state_nxt;
  logic [IDW-1:0]  w_idx_nxt;
  logic            w_xfer;
  logic            w_last_pos;
  logic            w_wr;
  logic            w_load;
  logic [N-1:0]    w_pend_nxt;

  // Ready depends only on registered state, so it never depends on the upstream valid.
  assign s_axis_tready = (r_state != ST_PRESENT);
  assign w_xfer        = s_axis_tvalid && s_axis_tready;
  assign w_last_pos    = (r_idx == IDW'(N-1));

`ifdef STREAM_DESERIALIZER_CHECK_EN
  logic r_err;
  logic w_err_nxt;
  logic w_bad;
  assign w_bad = (s_axis_tid != TIDW'(r_idx)) || (s_axis_tlast != w_last_pos);
  assign err   = r_err;
`else
  logic w_unused;
  assign w_unused = ^{s_axis_tid, s_axis_tlast};
  assign err      = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pend_nxt[i] = r_mvalid[i] & ~m_axis_tready[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr        = 1'b0;
    w_load      = 1'b0;
`ifdef STREAM_DESERIALIZER_CHECK_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      ST_FILL: begin
        if (w_xfer) begin
`ifdef STREAM_DESERIALIZER_CHECK_EN
          if (w_bad) begin
            w_err_nxt   = 1'b1;
            w_idx_nxt   = '0;
            // A bad word that carries tlast already closes the broken frame.
            w_state_nxt = s_axis_tlast ? ST_FILL : ST_DROP;
          end else
`endif
          if (w_last_pos) begin
            w_idx_nxt   = '0;
            w_load      = 1'b1;
            w_state_nxt = ST_PRESENT;
          end else begin
            w_wr      = 1'b1;
            w_idx_nxt = r_idx + IDW'(1);
          end
        end
      end
      ST_PRESENT: begin
        if (w_pend_nxt == '0) w_state_nxt = ST_FILL;
      end
`ifdef STREAM_DESERIALIZER_CHECK_EN
      ST_DROP: begin
        if (w_xfer && s_axis_tlast) w_state_nxt = ST_FILL;
      end
`endif
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // The buffer needs no reset: an entry is read only after it has been written in the same frame.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_idx] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_idx    <= '0;
      r_mvalid <= '0;
      for (int i = 0; i < N; i++) r_mdata[i] <= '0;
`ifdef STREAM_DESERIALIZER_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
`ifdef STREAM_DESERIALIZER_CHECK_EN
      r_err   <= w_err_nxt;
`endif
      if (w_load) begin
        // The final word goes straight from the input to its lane and bypasses the buffer.
        for (int i = 0; i < N; i++) begin
          if (i == N-1) r_mdata[i] <= s_axis_tdata;
          else          r_mdata[i] <= r_buf[i];
        end
        r_mvalid <= '1;
      end else begin
        r_mvalid <= w_pend_nxt;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign m_axis_tdata[g]  = r_mdata[g];
    assign m_axis_tvalid[g] = r_mvalid[g];
  end

endmodule

// File: tb/tb_stream_deserializer.sv
// -----------------------------------------------------------------------------
// tb_stream_deserializer
//   Directed frame scenarios followed by a randomized run. The DUT is compared
//   every cycle against a queue-based frame model, with extra constant checks
//   at the interesting points.
// -----------------------------------------------------------------------------
module tb_stream_deserializer;
  localparam int DW   = 24;
  localparam int N    = 4;
  localparam int TIDW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [TIDW-1:0] s_axis_tid;
  logic            s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata  [N];
  logic            m_axis_tvalid [N];
  logic            m_axis_tready [N];
  logic            err;

  stream_deserializer #(.DW(DW), .N(N), .TIDW(TIDW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tid(s_axis_tid),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: words collected so far, plus the frame currently on the lanes.
  bit            m_present;
  bit            m_drop;
  logic [DW-1:0] m_words[$];
  logic [DW-1:0] m_data  [N];
  bit            m_valid [N];
  bit            m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_present = 1'b0;
    m_drop    = 1'b0;
    m_words.delete();
    m_err     = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("s_ready", 32'(s_axis_tready), 32'(!m_present));
    chk("err", 32'(err), 32'(m_err));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid%0d", i), 32'(m_axis_tvalid[i]), 32'(m_valid[i]));
      chk($sformatf("data%0d", i), 32'(m_axis_tdata[i]), 32'(m_data[i]));
    end
  endtask

  // Drives one cycle from a negedge, checks current outputs, and advances the model.
  task automatic cycle(input bit sv, input logic [DW-1:0] d, input int tid, input bit tl,
                       input logic [N-1:0] mr, output bit acc);
    bit any;
    bit bad;
    int pos;
    s_axis_tvalid = sv;
    s_axis_tdata  = d;
    s_axis_tid    = TIDW'(tid);
    s_axis_tlast  = tl;
    for (int i = 0; i < N; i++) m_axis_tready[i] = mr[i];
    check_outputs();
    acc   = sv && !m_present;
    m_err = 1'b0;
    if (m_present) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (m_valid[i] && mr[i]) m_valid[i] = 1'b0;
      for (int i = 0; i < N; i++) any |= m_valid[i];
      if (!any) m_present = 1'b0;
    end else if (sv) begin
      if (m_drop) begin
        if (tl) m_drop = 1'b0;
      end else begin
        pos = m_words.size();
        bad = 1'b0;
`ifdef STREAM_DESERIALIZER_CHECK_EN
        bad = (tid != pos) || (tl != (pos == N-1));
`endif
        if (bad) begin
          m_err = 1'b1;
          m_words.delete();
          m_drop = !tl;
        end else begin
          m_words.push_back(d);
          if (m_words.size() == N) begin
            for (int i = 0; i < N; i++) begin
              m_data[i]  = m_words[i];
              m_valid[i] = 1'b1;
            end
            m_present = 1'b1;
            m_words.delete();
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int tid, input bit tl, input logic [N-1:0] mr);
    bit acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, d, tid, tl, mr, acc);
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input logic [N-1:0] mr);
    for (int k = 0; k < N; k++) send_word(base + DW'(k), k, (k == N-1), mr);
  endtask

  task automatic idle(input int n, input logic [N-1:0] mr);
    bit acc;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 0, 1'b0, mr, acc);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [DW-1:0] dat [8];
    int  k;
    int  seen;
    bit  acc;
    int  pos;
    logic [N-1:0] mr;

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < N; i++) m_axis_tready[i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(s_axis_tready), 32'd1);
    chk("rst_valid0", 32'(m_axis_tvalid[0]), 32'd0);
    chk("rst_data3", 32'(m_axis_tdata[3]), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle(2, '1);

    // 1: single frame, all lanes ready
    send_frame(24'h10, '1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t1_data%0d", i), 32'(m_axis_tdata[i]), 32'h10 + 32'(i));
      chk($sformatf("t1_valid%0d", i), 32'(m_axis_tvalid[i]), 32'd1);
    end
    chk("t1_ready_low", 32'(s_axis_tready), 32'd0);
    idle(1, '1);
    chk("t1_ready_back", 32'(s_axis_tready), 32'd1);
    chk("t1_valid_gone", 32'(m_axis_tvalid[2]), 32'd0);

    // 2: staggered lane acceptance
    send_frame(24'h10, '0);
    idle(1, 4'b0001);
    idle(1, 4'b1100);
    idle(1, 4'b0000);
    chk("t2_lane1_held", 32'(m_axis_tdata[1]), 32'h11);
    chk("t2_lane1_valid", 32'(m_axis_tvalid[1]), 32'd1);
    chk("t2_lane0_done", 32'(m_axis_tvalid[0]), 32'd0);
    chk("t2_ready_low", 32'(s_axis_tready), 32'd0);
    idle(1, 4'b0010);
    chk("t2_ready_back", 32'(s_axis_tready), 32'd1);
    idle(1, '1);

    // 3: back-to-back frames with valid held high
    for (int i = 0; i < 4; i++) dat[i] = 24'h18 + DW'(i);
    for (int i = 0; i < 4; i++) dat[4+i] = 24'h20 + DW'(i);
    k = 0;
    seen = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      cycle(1'b1, dat[k], k % N, (k % N) == N-1, '1, acc);
      if (acc) k++;
      if (m_axis_tvalid[0] && m_axis_tdata[0] == 24'h20) seen++;
    end
    idle(1, '1);
    if (m_axis_tvalid[0] && m_axis_tdata[0] == 24'h20) seen++;
    chk("t3_all_sent", 32'(k), 32'd8);
    chk("t3_frame2_once", 32'(seen), 32'd1);
    idle(1, '1);

    // 4: reset in the middle of a frame
    send_word(24'h3A, 0, 1'b0, '1);
    send_word(24'h3B, 1, 1'b0, '1);
    pulse_reset();
    chk("t4_rst_ready", 32'(s_axis_tready), 32'd1);
    send_frame(24'h30, '0);
    for (int i = 0; i < N; i++)
      chk($sformatf("t4_data%0d", i), 32'(m_axis_tdata[i]), 32'h30 + 32'(i));
    idle(2, '1);

`ifdef STREAM_DESERIALIZER_CHECK_EN
    // 5: bad tid, then drop up to tlast
    send_word(24'h70, 0, 1'b0, '1);
    send_word(24'h71, 2, 1'b0, '1);
    chk("t5_err_pulse", 32'(err), 32'd1);
    send_word(24'h72, 2, 1'b0, '1);
    chk("t5_err_once", 32'(err), 32'd0);
    send_word(24'h73, 3, 1'b1, '1);
    send_frame(24'h40, '0);
    for (int i = 0; i < N; i++)
      chk($sformatf("t5_data%0d", i), 32'(m_axis_tdata[i]), 32'h40 + 32'(i));
    idle(2, '1);

    // 6: early tlast returns straight to FILL
    send_word(24'h60, 0, 1'b0, '1);
    send_word(24'h61, 1, 1'b1, '1);
    chk("t6_err_pulse", 32'(err), 32'd1);
    send_frame(24'h62, '0);
    for (int i = 0; i < N; i++)
      chk($sformatf("t6_data%0d", i), 32'(m_axis_tdata[i]), 32'h62 + 32'(i));
    idle(2, '1);
`else
    // 6: early tlast is ignored, frame formed from arrival order
    send_word(24'h50, 0, 1'b0, '1);
    send_word(24'h51, 1, 1'b1, '1);
    chk("t6_no_err", 32'(err), 32'd0);
    send_word(24'h52, 2, 1'b0, '1);
    send_word(24'h53, 3, 1'b1, '0);
    for (int i = 0; i < N; i++)
      chk($sformatf("t6_data%0d", i), 32'(m_axis_tdata[i]), 32'h50 + 32'(i));
    chk("t6_err_still0", 32'(err), 32'd0);
    idle(2, '1);
`endif

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        pulse_reset();
      end else begin
        pos = m_words.size();
        mr  = N'($urandom);
        if ($urandom_range(40) == 0)
          cycle($urandom_range(9) < 7, DW'($urandom), int'($urandom_range(N-1)), 1'($urandom), mr, acc);
        else
          cycle($urandom_range(9) < 7, DW'($urandom), pos, (pos == N-1), mr, acc);
      end
    end
    idle(8, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
